// File: rtl/multicycle_control_fsm.sv
// Main sequencing FSM for the multicycle core: fetch, decode and per-opcode
// execute states, driving ALUOp and all datapath / memory strobes.
// Optional build macro: MULDIV_WATCHDOG_EN adds a MUL/DIV wait watchdog that
// pulses timeout_err; without it the FSM waits on alu_done indefinitely.
//
// Outputs are registered decodes of the next state and latched opcode, so
// they line up with the state they describe. Strobes that complete a
// handshake (ir_write/pc_inc, SW and MUL/DIV completion, conditional
// pc_write) are a registered enable qualified by the handshake input in
// that same cycle, and are suppressed while reset is high so no partial
// access completes under reset.
module multicycle_control_fsm #(
  parameter int OPW         = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           cond_true,
  input  logic           mem_ready,
  input  logic           alu_done,
  output logic [5:0]     alu_op,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           addr_sel,
  output logic           ir_write,
  output logic           pc_inc,
  output logic           pc_write,
  output logic           reg_write,
  output logic           flag_write,
  output logic           instr_done,
  output logic           illegal_op,
  output logic           timeout_err
);

  localparam logic [OPW-1:0] OP_LW   = OPW'(0);
  localparam logic [OPW-1:0] OP_SW   = OPW'(1);
  localparam logic [OPW-1:0] OP_MOV  = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(4);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(6);
  localparam logic [OPW-1:0] OP_AND  = OPW'(7);
  localparam logic [OPW-1:0] OP_OR   = OPW'(8);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(9);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(10);
  localparam logic [OPW-1:0] OP_CMP  = OPW'(11);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(12);
  localparam logic [OPW-1:0] OP_JR   = OPW'(13);
  localparam logic [OPW-1:0] OP_JPC  = OPW'(14);
  localparam logic [OPW-1:0] OP_BRFL = OPW'(15);
  localparam logic [OPW-1:0] OP_CALL = OPW'(16);
  localparam logic [OPW-1:0] OP_RET  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(18);

  localparam logic [5:0] A_LW1  = 6'd0;
  localparam logic [5:0] A_LW2  = 6'd1;
  localparam logic [5:0] A_LW3  = 6'd2;
  localparam logic [5:0] A_SW1  = 6'd3;
  localparam logic [5:0] A_SW2  = 6'd4;
  localparam logic [5:0] A_MOV  = 6'd5;
  localparam logic [5:0] A_ADD  = 6'd6;
  localparam logic [5:0] A_SUB  = 6'd7;
  localparam logic [5:0] A_MUL  = 6'd8;
  localparam logic [5:0] A_DIV  = 6'd9;
  localparam logic [5:0] A_AND  = 6'd10;
  localparam logic [5:0] A_OR   = 6'd11;
  localparam logic [5:0] A_SHL  = 6'd12;
  localparam logic [5:0] A_SHR  = 6'd13;
  localparam logic [5:0] A_CMP  = 6'd14;
  localparam logic [5:0] A_NOT  = 6'd15;
  localparam logic [5:0] A_JR   = 6'd16;
  localparam logic [5:0] A_JPC  = 6'd17;
  localparam logic [5:0] A_BRFL = 6'd18;
  localparam logic [5:0] A_CALL = 6'd19;
  localparam logic [5:0] A_RET  = 6'd20;
  localparam logic [5:0] A_NOP  = 6'd21;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EX1,
    S_EX2,
    S_EX3
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] opc_q, opc_d;

  logic [5:0] alu_op_q, alu_op_d;
  logic       mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;
  logic       addr_sel_q, addr_sel_d;
  logic       regw_q, regw_d;
  logic       flagw_q, flagw_d;
  logic       pcw_q, pcw_d;
  logic       done_q, done_d;
  logic       ill_q, ill_d;
  logic       fetch_en_q, fetch_en_d;
  logic       sw_en_q, sw_en_d;
  logic       md_en_q, md_en_d;
  logic       cond_en_q, cond_en_d;

  logic ready_ok;
  logic alu_done_ok;
  logic fetch_acc;
  logic sw_acc;
  logic md_acc;
  logic md_stop;
  logic wd_hit;

  // ALUOp for the single-step register ops and the other EX1-coded opcodes
  function automatic logic [5:0] ex1_alu(input logic [OPW-1:0] op);
    logic [5:0] a;
    a = A_NOP;
    case (op)
      OP_MOV:  a = A_MOV;
      OP_ADD:  a = A_ADD;
      OP_SUB:  a = A_SUB;
      OP_MUL:  a = A_MUL;
      OP_DIV:  a = A_DIV;
      OP_AND:  a = A_AND;
      OP_OR:   a = A_OR;
      OP_SHL:  a = A_SHL;
      OP_SHR:  a = A_SHR;
      OP_CMP:  a = A_CMP;
      OP_NOT:  a = A_NOT;
      OP_JR:   a = A_JR;
      OP_JPC:  a = A_JPC;
      OP_BRFL: a = A_BRFL;
      OP_CALL: a = A_CALL;
      OP_RET:  a = A_RET;
      default: a = A_NOP;
    endcase
    return a;
  endfunction

  assign ready_ok    = mem_ready & ~reset;
  assign alu_done_ok = alu_done & ~reset;
  assign fetch_acc   = fetch_en_q & ready_ok;
  assign sw_acc      = sw_en_q & ready_ok;
  assign md_acc      = md_en_q & alu_done_ok;
  assign md_stop     = md_acc | wd_hit;

`ifdef MULDIV_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  logic [WDW-1:0] wd_q, wd_d;

  // Count consecutive MUL/DIV wait cycles; cleared whenever not waiting
  always_comb begin
    wd_d = '0;
    if (md_en_q && !alu_done) wd_d = wd_q + 1'b1;
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign wd_hit      = md_en_q & ~alu_done & ~reset & (wd_q == WDW'(TIMEOUT_CYC - 1));
  assign timeout_err = wd_hit;
`else
  // Watchdog compiled out: the limit has no effect and the MUL/DIV wait is unbounded
  assign wd_hit      = (TIMEOUT_CYC < 0) ? 1'b1 : 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state selection, then registered-output decode of that next state
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    alu_op_d   = A_NOP;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    addr_sel_d = 1'b0;
    regw_d     = 1'b0;
    flagw_d    = 1'b0;
    pcw_d      = 1'b0;
    done_d     = 1'b0;
    ill_d      = 1'b0;
    fetch_en_d = 1'b0;
    sw_en_d    = 1'b0;
    md_en_d    = 1'b0;
    cond_en_d  = 1'b0;

    if (reset) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (fetch_acc) state_d = S_DECODE;
        S_DECODE: begin
          opc_d   = opcode;
          state_d = S_EX1;
        end
        S_EX1: begin
          case (opc_q)
            OP_LW, OP_SW:     state_d = S_EX2;
            OP_MUL, OP_DIV:   if (md_stop) state_d = S_FETCH;
            OP_CALL, OP_RET:  if (ready_ok) state_d = S_EX2;
            default:          state_d = S_FETCH;
          endcase
        end
        S_EX2: begin
          case (opc_q)
            OP_LW:   if (ready_ok) state_d = S_EX3;
            OP_SW:   if (ready_ok) state_d = S_FETCH;
            default: state_d = S_FETCH;
          endcase
        end
        default:  state_d = S_FETCH;
      endcase
    end

    case (state_d)
      S_FETCH: begin
        mem_rd_d   = 1'b1;
        fetch_en_d = 1'b1;
      end
      S_EX1: begin
        case (opc_d)
          OP_LW: alu_op_d = A_LW1;
          OP_SW: alu_op_d = A_SW1;
          OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_NOT: begin
            alu_op_d = ex1_alu(opc_d);
            regw_d   = 1'b1;
            done_d   = 1'b1;
          end
          OP_CMP: begin
            alu_op_d = A_CMP;
            flagw_d  = 1'b1;
            done_d   = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            alu_op_d = ex1_alu(opc_d);
            md_en_d  = 1'b1;
          end
          OP_JR: begin
            alu_op_d = A_JR;
            pcw_d    = 1'b1;
            done_d   = 1'b1;
          end
          OP_JPC, OP_BRFL: begin
            alu_op_d  = ex1_alu(opc_d);
            cond_en_d = 1'b1;
            done_d    = 1'b1;
          end
          OP_CALL: begin
            alu_op_d   = A_CALL;
            mem_wr_d   = 1'b1;
            addr_sel_d = 1'b1;
          end
          OP_RET: begin
            alu_op_d   = A_RET;
            mem_rd_d   = 1'b1;
            addr_sel_d = 1'b1;
          end
          OP_NOP: done_d = 1'b1;
          default: begin
            ill_d  = 1'b1;
            done_d = 1'b1;
          end
        endcase
      end
      S_EX2: begin
        case (opc_d)
          OP_LW: begin
            alu_op_d   = A_LW2;
            mem_rd_d   = 1'b1;
            addr_sel_d = 1'b1;
          end
          OP_SW: begin
            alu_op_d   = A_SW2;
            mem_wr_d   = 1'b1;
            addr_sel_d = 1'b1;
            sw_en_d    = 1'b1;
          end
          OP_CALL, OP_RET: begin
            alu_op_d = ex1_alu(opc_d);
            pcw_d    = 1'b1;
            done_d   = 1'b1;
          end
          default: alu_op_d = A_NOP;
        endcase
      end
      S_EX3: begin
        alu_op_d = A_LW3;
        regw_d   = 1'b1;
        done_d   = 1'b1;
      end
      default: alu_op_d = A_NOP;
    endcase
  end

  // State and registered-output flops; reset parks in FETCH with all strobes low
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      alu_op_q   <= A_NOP;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      addr_sel_q <= 1'b0;
      regw_q     <= 1'b0;
      flagw_q    <= 1'b0;
      pcw_q      <= 1'b0;
      done_q     <= 1'b0;
      ill_q      <= 1'b0;
      fetch_en_q <= 1'b0;
      sw_en_q    <= 1'b0;
      md_en_q    <= 1'b0;
      cond_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_op_q   <= alu_op_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      addr_sel_q <= addr_sel_d;
      regw_q     <= regw_d;
      flagw_q    <= flagw_d;
      pcw_q      <= pcw_d;
      done_q     <= done_d;
      ill_q      <= ill_d;
      fetch_en_q <= fetch_en_d;
      sw_en_q    <= sw_en_d;
      md_en_q    <= md_en_d;
      cond_en_q  <= cond_en_d;
    end
  end

  // Opcode latch, loaded only in DECODE
  always_ff @(posedge clk) begin
    opc_q <= opc_d;
  end

  assign alu_op     = alu_op_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign addr_sel   = addr_sel_q;
  assign ir_write   = fetch_acc;
  assign pc_inc     = fetch_acc;
  assign reg_write  = regw_q | md_acc;
  assign flag_write = flagw_q;
  assign pc_write   = pcw_q | (cond_en_q & cond_true & ~reset);
  assign instr_done = done_q | sw_acc | md_stop;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: a driver plays whole
// instructions with random handshake delays and pushes the expected
// per-instruction record; a monitor folds the observed outputs into the same
// record shape and compares whenever instr_done is seen.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] opcode = '0;
  logic       cond_true = 1'b0;
  logic       mem_ready = 1'b0;
  logic       alu_done = 1'b0;
  logic [5:0] alu_op;
  logic       mem_rd, mem_wr, addr_sel, ir_write, pc_inc, pc_write;
  logic       reg_write, flag_write, instr_done, illegal_op, timeout_err;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.OPW(5), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .cond_true(cond_true),
    .mem_ready(mem_ready), .alu_done(alu_done), .alu_op(alu_op),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
    .ir_write(ir_write), .pc_inc(pc_inc), .pc_write(pc_write),
    .reg_write(reg_write), .flag_write(flag_write), .instr_done(instr_done),
    .illegal_op(illegal_op), .timeout_err(timeout_err)
  );

  // strobe flags for one expected cycle
  localparam logic [8:0] RD = 9'h100, WR = 9'h080, AS = 9'h040, IR = 9'h020,
                         PW = 9'h010, RW = 9'h008, FW = 9'h004, IL = 9'h002,
                         DN = 9'h001, NONE = 9'h000;

  typedef struct packed {
    logic [31:0] cycles;
    logic [31:0] sig;
    logic [31:0] nreg;
    logic [31:0] nflag;
    logic [31:0] npc;
    logic [31:0] nill;
  } rec_t;

  rec_t sb_q[$];
  rec_t acc = '0;
  rec_t obs = '0;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] mix(input logic [31:0] s, input logic [15:0] v);
    return (s * 32'd1000003) ^ {16'h0, v};
  endfunction

  function automatic logic rb();
    return 1'($urandom & 32'd1);
  endfunction

  function automatic logic [4:0] junk();
    return 5'($urandom);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, fold the expected outputs into the record
  task automatic cyc(input logic [5:0] a, input logic [8:0] st, input logic mr,
                     input logic ad, input logic ct, input logic [4:0] opc);
    mem_ready = mr;
    alu_done  = ad;
    cond_true = ct;
    opcode    = opc;
    acc.cycles = acc.cycles + 32'd1;
    acc.sig    = mix(acc.sig, {a, st[8], st[7], st[6], st[5], st[5], st[4],
                               st[3], st[2], st[1], 1'b0});
    acc.nreg   = acc.nreg + 32'(st[3]);
    acc.nflag  = acc.nflag + 32'(st[2]);
    acc.npc    = acc.npc + 32'(st[4]);
    acc.nill   = acc.nill + 32'(st[1]);
    if (st[0]) begin
      sb_q.push_back(acc);
      acc = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    alu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_op", 32'(alu_op), 32'd21);
    check("rst_strobes", 32'({mem_rd, mem_wr, addr_sel, ir_write, pc_inc, pc_write,
                              reg_write, flag_write, instr_done, illegal_op, timeout_err}), 32'd0);
    reset = 1'b0;
    acc = '0;
    // first post-reset FETCH cycle has reset-valued outputs and takes no ready
    cyc(6'd21, NONE, 1'b0, rb(), rb(), junk());
  endtask

  // Reference model: one instruction as the spec's list of phases
  task automatic run_instr(input logic [4:0] op, input int fwait, input int mwait,
                           input int await_n, input logic c);
    logic [5:0] ac;
    ac = (op >= 5'd2 && op <= 5'd18) ? 6'(op + 5'd3) : 6'd21;
    for (int i = 0; i < fwait; i++) cyc(6'd21, RD, 1'b0, rb(), rb(), junk());
    cyc(6'd21, RD | IR, 1'b1, rb(), rb(), junk());
    cyc(6'd21, NONE, rb(), rb(), rb(), op);
    case (op)
      5'd0: begin
        cyc(6'd0, NONE, rb(), rb(), rb(), junk());
        for (int i = 0; i < mwait; i++) cyc(6'd1, RD | AS, 1'b0, rb(), rb(), junk());
        cyc(6'd1, RD | AS, 1'b1, rb(), rb(), junk());
        cyc(6'd2, RW | DN, rb(), rb(), rb(), junk());
      end
      5'd1: begin
        cyc(6'd3, NONE, rb(), rb(), rb(), junk());
        for (int i = 0; i < mwait; i++) cyc(6'd4, WR | AS, 1'b0, rb(), rb(), junk());
        cyc(6'd4, WR | AS | DN, 1'b1, rb(), rb(), junk());
      end
      5'd5, 5'd6: begin
        for (int i = 0; i < await_n; i++) cyc(ac, NONE, rb(), 1'b0, rb(), junk());
        cyc(ac, RW | DN, rb(), 1'b1, rb(), junk());
      end
      5'd11: cyc(ac, FW | DN, rb(), rb(), rb(), junk());
      5'd13: cyc(ac, PW | DN, rb(), rb(), rb(), junk());
      5'd14, 5'd15: cyc(ac, (c ? PW : NONE) | DN, rb(), rb(), c, junk());
      5'd16, 5'd17: begin
        for (int i = 0; i < mwait; i++)
          cyc(ac, ((op == 5'd16) ? WR : RD) | AS, 1'b0, rb(), rb(), junk());
        cyc(ac, ((op == 5'd16) ? WR : RD) | AS, 1'b1, rb(), rb(), junk());
        cyc(ac, PW | DN, rb(), rb(), rb(), junk());
      end
      5'd18: cyc(6'd21, DN, rb(), rb(), rb(), junk());
      5'd2, 5'd3, 5'd4, 5'd7, 5'd8, 5'd9, 5'd10, 5'd12:
        cyc(ac, RW | DN, rb(), rb(), rb(), junk());
      default: cyc(6'd21, IL | DN, rb(), rb(), rb(), junk());
    endcase
  endtask

  // Monitor: accumulate observed outputs, compare a record on each instr_done
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        obs = '0;
      end else begin
        obs.cycles = obs.cycles + 32'd1;
        obs.sig    = mix(obs.sig, {alu_op, mem_rd, mem_wr, addr_sel, ir_write, pc_inc,
                                   pc_write, reg_write, flag_write, illegal_op, timeout_err});
        obs.nreg   = obs.nreg + 32'(reg_write);
        obs.nflag  = obs.nflag + 32'(flag_write);
        obs.npc    = obs.npc + 32'(pc_write);
        obs.nill   = obs.nill + 32'(illegal_op);
        check("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
        check("write_onehot0", 32'((32'(reg_write) + 32'(flag_write) + 32'(pc_write)) > 32'd1), 32'd0);
        if (instr_done) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done: instr_done=1 with no instruction expected to finish");
          end else begin
            e = sb_q.pop_front();
            check("instr_cycles", obs.cycles, e.cycles);
            check("output_trace", obs.sig, e.sig);
            check("reg_write_cnt", obs.nreg, e.nreg);
            check("flag_write_cnt", obs.nflag, e.nflag);
            check("pc_write_cnt", obs.npc, e.npc);
            check("illegal_cnt", obs.nill, e.nill);
          end
          obs = '0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end

  // Driver: directed cases from the plan, random stream, mid-wait reset
  initial begin
    logic [4:0] op;
    do_reset();
    run_instr(5'd3, 0, 0, 0, 1'b0);
    run_instr(5'd0, 1, 2, 0, 1'b0);
    run_instr(5'd6, 0, 0, 9, 1'b0);
    run_instr(5'd14, 0, 0, 0, 1'b0);
    run_instr(5'd14, 0, 0, 0, 1'b1);
    run_instr(5'd25, 2, 0, 0, 1'b0);
    run_instr(5'd18, 0, 0, 0, 1'b0);

    for (int n = 0; n < 160; n++) begin
      op = (($urandom % 8) == 0) ? 5'(19 + ($urandom % 13)) : 5'($urandom % 19);
      run_instr(op, int'($urandom % 4), int'($urandom % 4), int'($urandom % 13), rb());
    end

    // SW interrupted by reset while waiting for the write to complete
    cyc(6'd21, RD | IR, 1'b1, 1'b0, 1'b0, junk());
    cyc(6'd21, NONE, 1'b0, 1'b0, 1'b0, 5'd1);
    cyc(6'd3, NONE, 1'b0, 1'b0, 1'b0, junk());
    cyc(6'd4, WR | AS, 1'b0, 1'b0, 1'b0, junk());
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("sw_wait_mem_wr", 32'(mem_wr), 32'd1);
    check("sw_no_done_in_reset", 32'(instr_done), 32'd0);
    @(posedge clk);
    #1;
    check("sw_rst_mem_wr", 32'(mem_wr), 32'd0);
    check("sw_rst_done", 32'(instr_done), 32'd0);
    check("sw_rst_alu_op", 32'(alu_op), 32'd21);
    reset = 1'b0;
    acc = '0;
    cyc(6'd21, NONE, 1'b0, 1'b0, 1'b0, junk());
    run_instr(5'd4, 1, 0, 0, 1'b0);
    run_instr(5'd16, 0, 2, 0, 1'b0);

    mem_ready = 1'b0;
    alu_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main sequencing FSM for the multicycle processor core. It fetches an instruction, decodes its opcode and steps the datapath through the per-instruction states. Each cycle it drives the 6-bit ALUOp code consumed by ALU control, along with all register, PC, flag and memory strobes. It handshakes with the memory interface (mem_ready) and with the iterative MUL/DIV unit (alu_done).

Parameters:
OPW, 5, opcode field width
TIMEOUT_CYC, 64, MUL/DIV watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
opcode  in  OPW  opcode field of the instruction register; sampled in DECODE
cond_true  in  1  condition/flag result for JPC and BRFL; sampled in EXEC
mem_ready  in  1  memory access complete (single-cycle pulse or held)
alu_done  in  1  MUL/DIV result valid
alu_op  out  6  ALUOp code to ALU control
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
addr_sel  out  1  0=PC, 1=ALU result/stack address
ir_write  out  1  load instruction register
pc_inc  out  1  PC <= PC+1
pc_write  out  1  PC <= ALU result / memory data
reg_write  out  1  register file write
flag_write  out  1  flags register write
instr_done  out  1  one-cycle pulse on the last cycle of every instruction
illegal_op  out  1  one-cycle pulse on an undefined opcode
timeout_err  out  1  watchdog pulse; tied 0 when the optional feature is compiled out

Behaviour:
- Opcode map: LW=0, SW=1, MOV=2, ADD=3, SUB=4, MUL=5, DIV=6, AND=7, OR=8, SHL=9, SHR=10, CMP=11, NOT=12, JR=13, JPC=14, BRFL=15, CALL=16, RET=17, NOP=18. Values 19 and above are illegal.
- alu_op codes: LW_1=0, LW_2=1, LW_3=2, SW_1=3, SW_2=4, MOV=5, ADD=6, SUB=7, MUL=8, DIV=9, AND=10, OR=11, SHL=12, SHR=13, CMP=14, NOT=15, JR=16, JPC=17, BRFL=18, CALL=19, RET=20, NOP=21.
- All outputs are registered Moore outputs derived from the state register and the latched opcode.
- Reset: state=FETCH; alu_op=21 (NOP); all strobes and pulses 0.
- States: FETCH, DECODE, EX1, EX2, EX3.
- FETCH: mem_rd=1, addr_sel=0. It stays in FETCH until mem_ready=1. On that cycle ir_write=1 and pc_inc=1, then the FSM moves to DECODE.
- DECODE (1 cycle): latch opcode internally; alu_op=NOP; go to EX1.
- LW:
  - EX1: alu_op=LW_1 (address computation).
  - EX2: alu_op=LW_2, mem_rd=1, addr_sel=1; hold until mem_ready.
  - EX3: alu_op=LW_3, reg_write=1, instr_done=1; go to FETCH.
- SW:
  - EX1: alu_op=SW_1.
  - EX2: alu_op=SW_2, mem_wr=1, addr_sel=1; hold until mem_ready. On the ready cycle instr_done=1; go to FETCH.
- MOV, ADD, SUB, AND, OR, SHL, SHR, NOT: EX1 only, with the matching alu_op, reg_write=1, instr_done=1; go to FETCH.
- CMP: EX1 with alu_op=CMP, flag_write=1 (reg_write=0), instr_done=1.
- MUL/DIV: EX1 with the matching alu_op. Hold in EX1 with alu_op stable until alu_done=1. On the done cycle reg_write=1 and instr_done=1.
- JR: EX1, alu_op=JR, pc_write=1.
- JPC/BRFL: EX1 with the matching alu_op; pc_write=cond_true, sampled that cycle.
- CALL:
  - EX1: alu_op=CALL, mem_wr=1, addr_sel=1 (push return PC); hold until mem_ready.
  - EX2: pc_write=1, instr_done=1.
- RET:
  - EX1: alu_op=RET, mem_rd=1, addr_sel=1; hold until mem_ready.
  - EX2: pc_write=1, instr_done=1.
- NOP: EX1 with alu_op=NOP, no strobes, instr_done=1.
- Illegal opcode: EX1 with alu_op=NOP, illegal_op=1, instr_done=1, no writes; go to FETCH.
- mem_rd and mem_wr are never asserted together. At most one of reg_write, flag_write and pc_write is asserted per cycle.
- If mem_ready and alu_done arrive together, only the signal relevant to the current state is acted on; the other is ignored.
- Reset asserted in any state, including mid-wait: the next state is FETCH and all strobes deassert on the following edge. No partial write completes after reset.

Optional Feature:
MULDIV_WATCHDOG_EN
- Defined: a counter runs while the FSM waits in EX1 for MUL/DIV. If alu_done has not arrived after TIMEOUT_CYC cycles, the FSM pulses timeout_err and instr_done, performs no reg_write and returns to FETCH.
- Undefined: the FSM waits indefinitely; timeout_err=0.

Test Plan:
- Reset, then ADD (opcode 3) with mem_ready on the 2nd FETCH cycle -> alu_op sequence 21,21,6; reg_write only on the EX1 cycle; instr_done 4 cycles after reset release.
- LW with mem_ready delayed 3 cycles in EX2 -> alu_op 0,1,1,1,2; mem_rd held during EX2; reg_write in EX3 only.
- DIV with alu_done after 10 cycles -> alu_op=9 held for 10 cycles, reg_write on the done cycle; with the watchdog macro and TIMEOUT_CYC=4 and no alu_done -> timeout_err pulse and no reg_write.
- JPC with cond_true=0, then with cond_true=1 -> pc_write 0, then 1; alu_op=17 both times.
- Opcode 25 -> illegal_op pulse, alu_op=21, no write strobes, back in FETCH the next cycle.
- Reset asserted during the SW EX2 wait -> mem_wr=0 on the next edge, state FETCH, no instr_done.
